// File: rtl/traffic_phase_sequencer.sv
// Traffic-light phase sequencer: drives lamps, requests each phase interval from a tick timer,
// latches pedestrian requests and falls back to a sticky all-red fault if the timer goes silent.
module traffic_phase_sequencer #(
  parameter logic [7:0] T_MAIN_G = 8'd20,
  parameter logic [7:0] T_SIDE_G = 8'd10,
  parameter logic [7:0] T_PED_G  = 8'd15,
  parameter logic [7:0] T_YELLOW = 8'd4,
  parameter logic [7:0] T_ALLRED = 8'd2,
  parameter logic [6:0] WD_LIMIT = 7'd64
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       tmr_expired,
  input  logic       ped_req,
  output logic       tmr_start,
  output logic [7:0] tmr_load,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic       fault
);

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StAr1   = 3'd1,
    StMg    = 3'd2,
    StMy    = 3'd3,
    StAr2   = 3'd4,
    StSg    = 3'd5,
    StSy    = 3'd6,
    StFault = 3'd7
  } state_e;

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  state_e     state_q, state_d;
  logic [6:0] wd_q, wd_d;
  logic       pend_q, pend_d;
  logic       start_q, start_d;
  logic [7:0] load_q, load_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       fault_q, fault_d;

  logic qual_exp;
  logic timed;
  logic entry;
  logic serve;

  // An expiry arriving in the same cycle as our start pulse belongs to the previous interval.
  assign qual_exp = tmr_expired & ~start_q;
  assign timed    = (state_q != StBoot) && (state_q != StFault);
  assign entry    = (state_d != state_q) && (state_d != StFault);
  assign serve    = pend_q | ped_req;

  // State and output registers
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
      wd_q    <= '0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      load_q  <= '0;
      main_q  <= LampRed;
      side_q  <= LampRed;
      walk_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      load_q  <= load_d;
      main_q  <= main_d;
      side_q  <= side_d;
      walk_q  <= walk_d;
      fault_q <= fault_d;
    end
  end

  // Next-state, watchdog and pedestrian latch
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StAr1;
      StAr1:   if (qual_exp) state_d = StMg;
      StMg:    if (qual_exp) state_d = StMy;
      StMy:    if (qual_exp) state_d = StAr2;
      StAr2:   if (qual_exp) state_d = StSg;
      StSg:    if (qual_exp) state_d = StSy;
      StSy:    if (qual_exp) state_d = StAr1;
      default: state_d = StFault;
    endcase
    if (timed && !qual_exp && (wd_q >= WD_LIMIT)) state_d = StFault;

    wd_d = wd_q;
    if (entry) begin
      wd_d = '0;
    end else if (timed && (state_d == state_q)) begin
      wd_d = wd_q + 7'd1;
    end

    pend_d = (entry && (state_d == StSg)) ? 1'b0 : serve;
  end

  // Registered output values for the state being entered
  always_comb begin
    main_d  = LampRed;
    side_d  = LampRed;
    unique case (state_d)
      StMg:    main_d = LampGreen;
      StMy:    main_d = LampYellow;
      StSg:    side_d = LampGreen;
      StSy:    side_d = LampYellow;
      default: ;
    endcase

    start_d = entry;
    load_d  = load_q;
    walk_d  = (state_d == StSg) ? walk_q : 1'b0;
    if (entry) begin
      unique case (state_d)
        StAr1, StAr2: load_d = T_ALLRED;
        StMg:         load_d = T_MAIN_G;
        StMy, StSy:   load_d = T_YELLOW;
        StSg: begin
          load_d = serve ? T_PED_G : T_SIDE_G;
          walk_d = serve;
        end
        default: ;
      endcase
    end

    fault_d = (state_d == StFault);
  end

  assign tmr_start  = start_q;
  assign tmr_load   = load_q;
  assign main_light = main_q;
  assign side_light = side_q;
  assign ped_walk   = walk_q;
  assign phase      = state_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomised bench for traffic_phase_sequencer: a phase-level reference model predicts every timer
// request into a scoreboard queue, and a negedge monitor checks outputs and pops on each tmr_start.
module tb_traffic_phase_sequencer;

  localparam int WdLimit = 64;

  logic       clk_out = 1'b0;
  logic       reset;
  logic       tmr_expired;
  logic       ped_req;
  logic       tmr_start;
  logic [7:0] tmr_load;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic [2:0] phase;
  logic       fault;

  traffic_phase_sequencer dut (
    .clk_out     (clk_out),
    .reset       (reset),
    .tmr_expired (tmr_expired),
    .ped_req     (ped_req),
    .tmr_start   (tmr_start),
    .tmr_load    (tmr_load),
    .main_light  (main_light),
    .side_light  (side_light),
    .ped_walk    (ped_walk),
    .phase       (phase),
    .fault       (fault)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    int unsigned ph;
    int unsigned load;
    int unsigned walk;
  } start_t;

  start_t exp_q[$];

  // Phase tables: successor, nominal interval, lamp codes {r,y,g} (4=red, 2=yellow, 1=green)
  int unsigned succ_tab[8] = '{1, 2, 3, 4, 5, 6, 1, 7};
  int unsigned load_tab[8] = '{0, 2, 20, 4, 2, 10, 4, 0};
  int unsigned main_tab[8] = '{4, 4, 1, 2, 4, 4, 4, 4};
  int unsigned side_tab[8] = '{4, 4, 4, 4, 4, 1, 2, 4};

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned m_phase = 0;
  int unsigned m_load  = 0;
  int unsigned m_walk  = 0;
  int          m_age   = 0;
  bit          m_fresh = 1'b0;
  bit          m_pend  = 1'b0;
  bit          chk_en  = 1'b0;

  int  mode      = 0;  // 0 timer, 1 expired held high, 2 silent, 3 random noise
  bit  armed     = 1'b0;
  int  cnt       = 0;
  int  dly_lo    = 3;
  int  dly_hi    = 3;
  int  ped_pct   = 0;
  bit  ped_force = 1'b0;
  int  n_starts  = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: one phase at a time, advanced by the spec's rules
  initial begin : model
    bit          was_fresh;
    int unsigned nxt;
    start_t      e;
    forever begin
      @(posedge clk_out or negedge reset);
      if (reset !== 1'b1) begin
        m_phase = 0;
        m_load  = 0;
        m_walk  = 0;
        m_age   = 0;
        m_fresh = 1'b0;
        m_pend  = 1'b0;
        exp_q.delete();
      end else begin
        was_fresh = m_fresh;
        m_fresh   = 1'b0;
        nxt       = m_phase;
        if (m_phase == 0) begin
          nxt = 1;
        end else if (m_phase != 7) begin
          m_age++;
          if (tmr_expired && !was_fresh) nxt = succ_tab[m_phase];
          else if (m_age > WdLimit) nxt = 7;
        end
        if (nxt != m_phase && nxt != 7) begin
          m_phase = nxt;
          m_fresh = 1'b1;
          m_age   = 0;
          m_load  = load_tab[nxt];
          m_walk  = 0;
          if (nxt == 5) begin
            if (m_pend || ped_req) begin
              m_walk = 1;
              m_load = 15;
            end
            m_pend = 1'b0;
          end else if (ped_req) begin
            m_pend = 1'b1;
          end
          e.ph   = nxt;
          e.load = m_load;
          e.walk = m_walk;
          exp_q.push_back(e);
        end else begin
          if (nxt == 7) begin
            m_phase = 7;
            m_walk  = 0;
          end
          if (ped_req) m_pend = 1'b1;
        end
      end
    end
  end

  // Monitor: per-cycle lamp/status checks plus scoreboard pop on every start pulse
  initial begin : monitor
    start_t e;
    forever begin
      @(negedge clk_out);
      if (chk_en) begin
        cmp("phase", int'(phase), int'(m_phase));
        cmp("main_light", int'(main_light), int'(main_tab[m_phase]));
        cmp("side_light", int'(side_light), int'(side_tab[m_phase]));
        cmp("fault", int'(fault), (m_phase == 7) ? 1 : 0);
        cmp("ped_walk", int'(ped_walk), int'(m_walk));
        cmp("tmr_load", int'(tmr_load), int'(m_load));
        cmp("both_green", int'(main_light[0] & side_light[0]), 0);
        if (tmr_start === 1'b1) begin
          n_starts++;
          if (exp_q.size() == 0) begin
            cmp("unexpected_start", 1, 0);
          end else begin
            e = exp_q.pop_front();
            cmp("start_phase", int'(phase), int'(e.ph));
            cmp("start_load", int'(tmr_load), int'(e.load));
            cmp("start_walk", int'(ped_walk), int'(e.walk));
          end
        end else if (exp_q.size() != 0) begin
          cmp("missing_start", 0, 1);
          exp_q.delete();
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_out);
    tmr_expired = 1'b0;
    case (mode)
      0: begin
        if (tmr_start === 1'b1) begin
          armed = 1'b1;
          cnt   = int'($urandom_range(dly_hi, dly_lo));
        end else if (armed) begin
          if (cnt <= 1) begin
            tmr_expired = 1'b1;
            armed       = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
      1:       tmr_expired = 1'b1;
      2:       tmr_expired = 1'b0;
      default: tmr_expired = ($urandom_range(3, 0) == 0);
    endcase
    ped_req   = ped_force || (int'($urandom_range(99, 0)) < ped_pct);
    ped_force = 1'b0;
  endtask

  task automatic set_mode(input int m);
    mode  = m;
    armed = (m == 0);
    cnt   = 2;
  endtask

  task automatic wait_start(input int p, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      step();
      hit = (tmr_start === 1'b1) && (int'(phase) == p);
    end
    cmp($sformatf("reach_phase%0d", p), int'(hit), 1);
  endtask

  initial begin : stim
    reset       = 1'b1;
    tmr_expired = 1'b0;
    ped_req     = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk_out);
    chk_en = 1'b1;

    // Reset held, then release: first edge enters AR1 with a 2-tick request
    repeat (3) step();
    cmp("rst_tmr_start", int'(tmr_start), 0);
    cmp("rst_main", int'(main_light), 4);
    cmp("rst_side", int'(side_light), 4);
    #2 reset = 1'b1;
    set_mode(0);
    armed = 1'b0;
    wait_start(1, 3);
    cmp("ar1_load", int'(tmr_load), 2);

    // Plain cycle, timer answers 3 cycles after each start
    repeat (45) step();

    // Pedestrian pulse during main green
    wait_start(2, 40);
    ped_force = 1'b1;
    step();
    wait_start(5, 40);
    cmp("ped_sg_load", int'(tmr_load), 15);
    cmp("ped_sg_walk", int'(ped_walk), 1);
    wait_start(6, 40);
    cmp("ped_sy_walk", int'(ped_walk), 0);
    wait_start(5, 60);
    cmp("next_sg_load", int'(tmr_load), 10);
    cmp("next_sg_walk", int'(ped_walk), 0);

    // Expired held high across entry edges
    set_mode(1);
    repeat (20) step();
    set_mode(0);

    // Timer goes silent after main green starts
    wait_start(2, 40);
    set_mode(2);
    repeat (70) step();
    cmp("wd_fault", int'(fault), 1);
    cmp("wd_main", int'(main_light), 4);
    cmp("wd_side", int'(side_light), 4);
    n_starts = 0;
    set_mode(3);
    repeat (20) step();
    cmp("fault_no_start", n_starts, 0);
    cmp("fault_phase", int'(phase), 7);

    // Leave fault via reset, then reset mid-SY with a request pending
    #2 reset = 1'b0;
    step();
    #2 reset = 1'b1;
    set_mode(0);
    armed = 1'b0;
    wait_start(6, 60);
    ped_force = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    #1 cmp("async_main", int'(main_light), 4);
    cmp("async_side", int'(side_light), 4);
    step();
    step();
    #2 reset = 1'b1;
    set_mode(0);
    armed = 1'b0;
    wait_start(5, 60);
    cmp("discard_load", int'(tmr_load), 10);
    cmp("discard_walk", int'(ped_walk), 0);

    // Randomised run: variable timer latency, noisy expiry, random pedestrians
    dly_lo  = 1;
    dly_hi  = 6;
    ped_pct = 15;
    for (int b = 0; b < 6; b++) begin
      set_mode(($urandom_range(2, 0) == 0) ? 3 : 0);
      repeat (50) step();
    end
    set_mode(0);
    repeat (5) step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
